// File: rtl/param_register_file.sv
// Two-read/one-write register file with optional write bypass, optional registered
// reads, optional hard-zero register 0, and a sequential clear engine.
module param_register_file #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_N      = 2**ADDR_WIDTH,
  parameter int REG_WIDTH  = 16,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1,
  parameter bit READ_REG   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [REG_WIDTH-1:0]  write_bus,
  input  logic [ADDR_WIDTH-1:0] read_1_addr,
  input  logic [ADDR_WIDTH-1:0] read_2_addr,
  output logic [REG_WIDTH-1:0]  read_bus_1,
  output logic [REG_WIDTH-1:0]  read_bus_2,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  write_rejected
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clear_cnt;
  logic                  r_clear_done;
  logic                  r_write_rejected;
  logic [REG_WIDTH-1:0]  r_regs [REG_N];

  logic                  w_idle;
  logic                  w_wr_accept;
  logic                  w_clear_last;
  logic [REG_WIDTH-1:0]  w_sel_1;
  logic [REG_WIDTH-1:0]  w_sel_2;

  assign w_idle       = (r_state == IDLE);
  assign w_wr_accept  = write_enabled && w_idle && !clear_req &&
                        !(ZERO_REG && (write_addr == '0));
  assign w_clear_last = (r_clear_cnt == ADDR_WIDTH'(REG_N - 1));

  assign busy           = (r_state == CLEAR);
  assign clear_done     = r_clear_done;
  assign write_rejected = r_write_rejected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_clear_cnt      <= '0;
      r_clear_done     <= 1'b0;
      r_write_rejected <= 1'b0;
    end else begin
      r_write_rejected <= write_enabled && !w_wr_accept;
      r_clear_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state     <= CLEAR;
            r_clear_cnt <= '0;
          end
        end
        CLEAR: begin
          if (w_clear_last) begin
            r_state      <= IDLE;
            r_clear_done <= 1'b1;
          end else begin
            r_clear_cnt <= r_clear_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Writes are never accepted during CLEAR, so the clear and write paths are exclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_state == CLEAR) begin
      r_regs[r_clear_cnt] <= '0;
    end else if (w_wr_accept) begin
      r_regs[write_addr] <= write_bus;
    end
  end

  always_comb begin
    w_sel_1 = r_regs[read_1_addr];
    w_sel_2 = r_regs[read_2_addr];
    if (BYPASS && w_wr_accept && (read_1_addr == write_addr)) w_sel_1 = write_bus;
    if (BYPASS && w_wr_accept && (read_2_addr == write_addr)) w_sel_2 = write_bus;
    if (ZERO_REG && (read_1_addr == '0)) w_sel_1 = '0;
    if (ZERO_REG && (read_2_addr == '0)) w_sel_2 = '0;
  end

  if (READ_REG) begin : g_rd_reg
    logic [REG_WIDTH-1:0] r_rd_1;
    logic [REG_WIDTH-1:0] r_rd_2;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rd_1 <= '0;
        r_rd_2 <= '0;
      end else begin
        r_rd_1 <= w_sel_1;
        r_rd_2 <= w_sel_2;
      end
    end

    assign read_bus_1 = r_rd_1;
    assign read_bus_2 = r_rd_2;
  end else begin : g_rd_comb
    assign read_bus_1 = w_sel_1;
    assign read_bus_2 = w_sel_2;
  end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: default instance plus a ZERO_REG/no-bypass/registered-read
// instance sharing one stimulus stream, both checked against an array-based reference model.
module tb_param_register_file;

  localparam int AW = 3;
  localparam int N  = 8;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic          creq;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [W-1:0]  wb;

  logic [W-1:0]  a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_busy, b_busy, a_done, b_done, a_rej, b_rej;

  always #5 clk = ~clk;

  param_register_file u_dut_a (
    .clk(clk), .reset(reset), .write_enabled(we), .write_addr(wa), .write_bus(wb),
    .read_1_addr(ra1), .read_2_addr(ra2), .read_bus_1(a_rd1), .read_bus_2(a_rd2),
    .clear_req(creq), .busy(a_busy), .clear_done(a_done), .write_rejected(a_rej)
  );

  param_register_file #(
    .ZERO_REG(1'b1),
    .BYPASS  (1'b0),
    .READ_REG(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .write_enabled(we), .write_addr(wa), .write_bus(wb),
    .read_1_addr(ra1), .read_2_addr(ra2), .read_bus_1(b_rd1), .read_bus_2(b_rd2),
    .clear_req(creq), .busy(b_busy), .clear_done(b_done), .write_rejected(b_rej)
  );

  // Reference model state
  logic [W-1:0] mem_a [N];
  logic [W-1:0] mem_b [N];
  logic [W-1:0] eb1, eb2;
  logic         ea_rej, eb_rej, e_done;
  int           clear_left;

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    eb1 = '0; eb2 = '0;
    ea_rej = 1'b0; eb_rej = 1'b0; e_done = 1'b0;
    clear_left = 0;
  endtask

  function automatic logic [W-1:0] exp_a(input logic [AW-1:0] addr);
    if (we && clear_left == 0 && !creq && addr == wa) return wb;
    return mem_a[addr];
  endfunction

  task automatic model_edge();
    bit acc_a, acc_b, was_busy;
    int idx;
    was_busy = (clear_left > 0);
    acc_a    = we && !was_busy && !creq;
    acc_b    = acc_a && (wa != 0);
    eb1      = (ra1 == 0) ? '0 : mem_b[ra1];
    eb2      = (ra2 == 0) ? '0 : mem_b[ra2];
    ea_rej   = we && !acc_a;
    eb_rej   = we && !acc_b;
    if (was_busy) begin
      idx = N - clear_left;
      mem_a[idx] = '0;
      mem_b[idx] = '0;
      clear_left--;
      e_done = (clear_left == 0);
    end else begin
      e_done = 1'b0;
      if (creq) clear_left = N;
    end
    if (acc_a) mem_a[wa] = wb;
    if (acc_b) mem_b[wa] = wb;
  endtask

  // Called at posedge+1 with inputs already set; checks mid-cycle, returns at next posedge+1.
  task automatic cycle();
    @(negedge clk);
    chk("a_rd1", a_rd1, exp_a(ra1));
    chk("a_rd2", a_rd2, exp_a(ra2));
    chk("b_rd1", b_rd1, eb1);
    chk("b_rd2", b_rd2, eb2);
    chk("a_busy", a_busy, clear_left > 0);
    chk("b_busy", b_busy, clear_left > 0);
    chk("a_done", a_done, e_done);
    chk("b_done", b_done, e_done);
    chk("a_rej", a_rej, ea_rej);
    chk("b_rej", b_rej, eb_rej);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; we = 1'b0; creq = 1'b0;
    wa = '0; wb = '0; ra1 = '0; ra2 = '0;
    model_reset();
    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rej", b_rej, 0);
    chk("rst_b_rd", b_rd1, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Bypass on the very first edge after reset release
    we = 1'b1; wa = 3'd3; wb = 16'hA5A5; ra1 = 3'd3; ra2 = 3'd3;
    #2;
    chk("byp_rd1", a_rd1, 16'hA5A5);
    chk("byp_rd2", a_rd2, 16'hA5A5);
    cycle();
    we = 1'b0;
    #2;
    chk("stored_rd1", a_rd1, 16'hA5A5);
    cycle();

    // No-bypass registered reads
    we = 1'b1; wa = 3'd5; wb = 16'h1111; ra1 = 3'd5;
    cycle();
    wb = 16'h2222;
    cycle();
    we = 1'b0;
    chk("nobyp_old", b_rd1, 16'h1111);
    cycle();
    chk("nobyp_new", b_rd1, 16'h2222);

    // Hard-zero register 0
    we = 1'b1; wa = 3'd0; wb = 16'hFFFF; ra1 = 3'd0;
    cycle();
    chk("zr_rej", b_rej, 1);
    chk("zr_rd", b_rd1, 0);
    we = 1'b0;
    cycle();
    chk("zr_rd_after", b_rd1, 0);

    // Fill, then full clear with a write attempted mid-clear
    for (int i = 0; i < N; i++) begin
      we = 1'b1; wa = AW'(i); wb = W'(16'h1111 * (i + 1));
      cycle();
    end
    we = 1'b0; creq = 1'b1;
    cycle();
    creq = 1'b0;
    busy_cnt = a_busy;
    done_cnt = a_done;
    for (int k = 0; k < 9; k++) begin
      we = (k == 3); wa = 3'd6; wb = 16'hBEEF;
      cycle();
      if (k == 3) chk("clr_wr_rej", a_rej, 1);
      busy_cnt += a_busy;
      done_cnt += a_done;
    end
    chk("clr_busy_cycles", busy_cnt, 8);
    chk("clr_done_pulses", done_cnt, 1);
    we = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra1 = AW'(i); ra2 = AW'(N - 1 - i);
      #2;
      chk("clr_all_zero", a_rd1, 0);
      cycle();
    end

    // Clear request wins over a simultaneous write
    we = 1'b1; wa = 3'd2; wb = 16'h1234;
    cycle();
    creq = 1'b1; wb = 16'h0F0F;
    cycle();
    chk("clr_prio_rej", a_rej, 1);
    we = 1'b0; creq = 1'b0;
    repeat (8) cycle();
    ra1 = 3'd2;
    #2;
    chk("clr_prio_reg2", a_rd1, 0);
    cycle();

    // Reset during the 4th clear cycle
    for (int i = 0; i < N; i++) begin
      we = 1'b1; wa = AW'(i); wb = W'($urandom_range(1, 16'hFFFF));
      cycle();
    end
    we = 1'b0; creq = 1'b1;
    cycle();
    creq = 1'b0;
    repeat (3) cycle();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("abort_busy_a", a_busy, 0);
    chk("abort_busy_b", b_busy, 0);
    for (int i = 0; i < N; i++) begin
      ra1 = AW'(i);
      #1;
      chk("abort_zero", a_rd1, 0);
    end
    @(posedge clk); #1;
    chk("abort_no_done", a_done, 0);
    reset = 1'b1;
    we = 1'b1; wa = 3'd4; wb = 16'h5A5A; ra1 = 3'd4;
    cycle();
    we = 1'b0;
    #2;
    chk("post_rst_wr", a_rd1, 16'h5A5A);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      we   = 1'($urandom_range(0, 1));
      creq = ($urandom_range(0, 24) == 0);
      wa   = AW'($urandom);
      wb   = W'($urandom);
      ra1  = AW'($urandom);
      ra2  = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom);
      if (($urandom_range(0, 3) == 0)) ra1 = wa;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
